// File: rtl/williams_mem_arbiter.sv
// williams_mem_arbiter
//   Shares one single-port memory between the CPU and the ROM download path.
//   Download bytes are queued in a small FIFO and written during idle slots;
//   the CPU is held off during a download and until the queue has drained.
//   Once that is no longer the case, the CPU gets at most MAX_CPU_RUN back-to-back
//   grants while the queue is non-empty, and then one queued byte is written.
//
// Ports
//   clk_sys, reset_n               clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_din CPU request (held until cpu_ack)
//   cpu_dout, cpu_ack              read data (valid with ack), 1-cycle ack
//   dl_active/dl_wr/dl_addr/dl_data download stream from the HPS
//   dl_wait, dl_ovf                backpressure, sticky dropped-byte flag
//   mem_addr/mem_din/mem_we        memory bus (registered)
//   mem_dout                       memory read data, one cycle after mem_addr
//   state_dbg                      current FSM state, for observation
//
// CPU handshake: cpu_req is raised with cpu_we/cpu_addr/cpu_din stable and held
// until the single-cycle cpu_ack. A write acks in the cycle after the grant
// edge; a read acks one cycle later, with cpu_dout valid in the ack cycle.
module williams_mem_arbiter #(
  parameter int MAX_CPU_RUN = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        dl_ovf,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic [2:0]  state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $clog2(MAX_CPU_RUN + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CPU_RD      = 3'd1,
    S_CPU_RD_DATA = 3'd2,
    S_CPU_WR      = 3'd3,
    S_DL_WR       = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] cnt_next;
  logic [RW-1:0] run_cnt;
  logic          drain_q;
  logic [7:0]    dout_q;

  logic fifo_empty;
  logic fifo_full;
  logic cpu_blocked;
  logic force_dl;
  logic grant_cpu;
  logic grant_dl;
  logic push;
  logic pop;

  always_comb begin
    fifo_empty  = (fifo_cnt == '0);
    fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
    // drain_q keeps the CPU off after a download ends until the queue is empty
    cpu_blocked = dl_active | drain_q;
    force_dl    = !fifo_empty && (run_cnt == RW'(MAX_CPU_RUN));
    grant_cpu   = (state == S_IDLE) && cpu_req && !cpu_blocked && !force_dl;
    grant_dl    = (state == S_IDLE) && !grant_cpu && !fifo_empty;
    pop         = grant_dl;
    // a full queue still accepts a byte when the head leaves on the same edge
    push        = dl_wr && (!fifo_full || pop);
    cnt_next    = fifo_cnt + CW'(push) - CW'(pop);
  end

  // Read data is passed straight through in the ack cycle and held afterwards.
  assign cpu_dout  = (state == S_CPU_RD_DATA) ? mem_dout : dout_q;
  assign state_dbg = state;

  // Queue storage carries no reset; only the pointers and count define content.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= dl_addr;
      fifo_data[wr_ptr] <= dl_data;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      run_cnt  <= '0;
      drain_q  <= 1'b0;
      dout_q   <= 8'h00;
      cpu_ack  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 16'h0000;
      mem_din  <= 8'h00;
      dl_wait  <= 1'b0;
      dl_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= cnt_next;
      dl_wait  <= (cnt_next >= CW'(FIFO_DEPTH - 1));
      if (dl_wr && !push) dl_ovf <= 1'b1;

      if (dl_active)       drain_q <= 1'b1;
      else if (fifo_empty) drain_q <= 1'b0;

      if (fifo_empty) run_cnt <= '0;

      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_cpu) begin
            mem_addr <= cpu_addr;
            run_cnt  <= fifo_empty ? '0 : run_cnt + RW'(1);
            if (cpu_we) begin
              mem_din <= cpu_din;
              mem_we  <= 1'b1;
              cpu_ack <= 1'b1;
              state   <= S_CPU_WR;
            end else begin
              state <= S_CPU_RD;
            end
          end else if (grant_dl) begin
            mem_addr <= fifo_addr[rd_ptr];
            mem_din  <= fifo_data[rd_ptr];
            mem_we   <= 1'b1;
            run_cnt  <= '0;
            state    <= S_DL_WR;
          end
        end
        S_CPU_RD: begin
          // memory returns data during the next cycle; ack lines up with it
          cpu_ack <= 1'b1;
          state   <= S_CPU_RD_DATA;
        end
        S_CPU_RD_DATA: begin
          dout_q <= mem_dout;
          state  <= S_IDLE;
        end
        S_CPU_WR: state <= S_IDLE;
        S_DL_WR:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_williams_mem_arbiter.sv
// Bench for williams_mem_arbiter: directed steps, a synchronous memory model
// and scoreboards for download writes and CPU read data.
module tb_williams_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        dl_ovf;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int dl_log_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic        ovf_model = 1'b0;

  williams_mem_arbiter #(.MAX_CPU_RUN(8), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wait(dl_wait), .dl_ovf(dl_ovf),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk_sys = ~clk_sys;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // memory model: one-cycle read latency, two preset locations
  always @(posedge clk_sys) begin
    if (mem_addr == 16'h1234)      mem_dout <= 8'h5A;
    else if (mem_addr == 16'h2000) mem_dout <= 8'hC3;
    else                           mem_dout <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (cpu_ack) ack_cnt++;
      if (cpu_ack && !mem_we) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_q.size()), 32'd1);
        else check("rd_data", 32'(cpu_dout), 32'(rd_q.pop_front()));
      end
      if (mem_we && !cpu_ack) begin
        dl_log_q.push_back(ack_cnt);
        if (exp_q.size() == 0) check("dl_unexpected", 32'(exp_q.size()), 32'd1);
        else check("dl_write", 32'({mem_addr, mem_din}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    tick();
    while (!cpu_ack && n < 60) begin
      tick();
      n++;
    end
    if (!cpu_ack) fail_now(tag);
  endtask

  task automatic wait_dl(input int target, input string tag);
    int n = 0;
    while (dl_log_q.size() < target && n < 600) begin
      tick();
      n++;
    end
    if (dl_log_q.size() < target) fail_now(tag);
  endtask

  // CPU streams writes; n_push download bytes arrive while the CPU owns the bus
  task automatic stream_run(input int n_push, input logic [15:0] base);
    int base_ack = 0;
    int seen0;
    int n_acc;
    logic [15:0] a_v;
    logic [7:0]  d_v;
    n_acc = (n_push < 4) ? n_push : 4;
    cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_din = 8'h11; cpu_req = 1'b1;
    repeat (4) tick();
    wait_ack("stream_align");
    seen0 = dl_log_q.size();
    for (int i = 0; i < n_push; i++) begin
      a_v = base + 16'(i);
      d_v = 8'h60 + 8'(i);
      dl_wr = 1'b1; dl_addr = a_v; dl_data = d_v;
      if (i < 4) exp_q.push_back({a_v, d_v});
      tick();
      if (i == 0) base_ack = ack_cnt;
      if (i >= 4) ovf_model = 1'b1;
      check("stream_wait", 32'(dl_wait), ((i + 1) >= 3) ? 32'd1 : 32'd0);
      check("stream_ovf", 32'(dl_ovf), 32'(ovf_model));
    end
    dl_wr = 1'b0;
    wait_dl(seen0 + n_acc, "stream_dl_timeout");
    if (dl_log_q.size() >= seen0 + n_acc) begin
      check("run_first", 32'(dl_log_q[seen0] - base_ack), 32'd8);
      for (int k = 1; k < n_acc; k++)
        check("run_gap", 32'(dl_log_q[seen0 + k] - dl_log_q[seen0 + k - 1]), 32'd8);
    end
    repeat (20) tick();
    check("stream_no_extra", 32'(dl_log_q.size() - seen0), 32'(n_acc));
    wait_ack("stream_stop");
    cpu_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int base;
    int seen;
    logic [15:0] a_v;
    logic [7:0]  d_v;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 16'h0000; dl_data = 8'h00;
    repeat (3) tick();
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wait", 32'(dl_wait), 32'd0);
    check("rst_ovf", 32'(dl_ovf), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    check("rst_dout", 32'(cpu_dout), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    tick();

    // single CPU read with the queue empty
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    rd_q.push_back(8'h5A);
    tick();
    check("rd_grant_addr", 32'(mem_addr), 32'h1234);
    check("rd_grant_we", 32'(mem_we), 32'd0);
    check("rd_grant_ack", 32'(cpu_ack), 32'd0);
    tick();
    check("rd_ack", 32'(cpu_ack), 32'd1);
    check("rd_ack_dout", 32'(cpu_dout), 32'h5A);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    check("rd_dout_hold", 32'(cpu_dout), 32'h5A);

    // download of five bytes with a CPU read held off meanwhile
    dl_active = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    rd_q.push_back(8'h5A);
    base = ack_cnt;
    seen = dl_log_q.size();
    for (int i = 0; i < 5; i++) begin
      a_v = 16'(i);
      d_v = 8'h30 + 8'(i);
      dl_wr = 1'b1; dl_addr = a_v; dl_data = d_v;
      exp_q.push_back({a_v, d_v});
      tick();
    end
    dl_wr = 1'b0;
    wait_dl(seen + 5, "dl_timeout");
    repeat (4) tick();
    check("dl_ovf_clear", 32'(dl_ovf), 32'd0);
    check("cpu_held", 32'(ack_cnt - base), 32'd0);
    check("dl_wait_drained", 32'(dl_wait), 32'd0);
    dl_active = 1'b0;
    wait_ack("rd_after_dl");
    cpu_req = 1'b0;
    repeat (2) tick();
    check("dl_queue_empty", 32'(exp_q.size()), 32'd0);

    // queue fills and overflows while the CPU streams, then drains fairly
    stream_run(6, 16'h4100);
    check("ovf_set", 32'(dl_ovf), 32'd1);

    // two queued bytes interleaved with continuous CPU traffic
    stream_run(2, 16'h4200);
    check("ovf_sticky", 32'(dl_ovf), 32'd1);

    // reset in the read data cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    rd_q.push_back(8'h5A);
    tick();
    tick();
    check("pre_rst_state", 32'(state_dbg), 32'd2);
    reset_n = 1'b0;
    rd_q.delete();
    ovf_model = 1'b0;
    #1;
    check("arst_ack", 32'(cpu_ack), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_din", 32'(mem_din), 32'd0);
    check("arst_dout", 32'(cpu_dout), 32'd0);
    check("arst_ovf", 32'(dl_ovf), 32'(ovf_model));
    check("arst_wait", 32'(dl_wait), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    cpu_req = 1'b0;
    #2;
    reset_n = 1'b1;
    base = ack_cnt;
    repeat (5) tick();
    check("no_ack_after_rst", 32'(ack_cnt - base), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    rd_q.push_back(8'hC3);
    wait_ack("rd_after_rst");
    check("rd_after_rst_dout", 32'(cpu_dout), 32'hC3);
    cpu_req = 1'b0;
    repeat (3) tick();
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("dl_queue_final", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
